// File: rtl/fc_layer_ctrl_if.sv
// Bus bundle between the fully-connected layer sequencer and its memories/core.
// The master side is the sequencer; the slave side is the memories, the MAC core
// and the output memory.
interface fc_layer_ctrl_if #(
    parameter int IN_DATA_WIDTH = 9,
    parameter int NUM_IN        = 16,
    parameter int NUM_OUT       = 8
);
    localparam int W    = IN_DATA_WIDTH;
    localparam int NA_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int WA_W = (NUM_IN * NUM_OUT > 1) ? $clog2(NUM_IN * NUM_OUT) : 1;
    localparam int OA_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    // node / weight / bias memory read port
    logic              o_rd_en;
    logic [NA_W-1:0]   o_node_addr;
    logic [WA_W-1:0]   o_wegt_addr;
    logic [OA_W-1:0]   o_bias_addr;
    logic [W-1:0]      i_node_rdata;
    logic [W-1:0]      i_wegt_rdata;
    logic [W-1:0]      i_bias_rdata;

    // MAC core port
    logic              o_core_run;
    logic              o_core_valid;
    logic [W-1:0]      o_core_node;
    logic [W-1:0]      o_core_wegt;
    logic [W-1:0]      o_core_bias;
    logic [4*W-1:0]    i_core_result;

    // output memory write port
    logic              o_out_we;
    logic [OA_W-1:0]   o_out_addr;
    logic [4*W-1:0]    o_out_data;

    modport master (
        output o_rd_en, o_node_addr, o_wegt_addr, o_bias_addr,
        input  i_node_rdata, i_wegt_rdata, i_bias_rdata,
        output o_core_run, o_core_valid, o_core_node, o_core_wegt, o_core_bias,
        input  i_core_result,
        output o_out_we, o_out_addr, o_out_data
    );

    modport slave (
        input  o_rd_en, o_node_addr, o_wegt_addr, o_bias_addr,
        output i_node_rdata, i_wegt_rdata, i_bias_rdata,
        input  o_core_run, o_core_valid, o_core_node, o_core_wegt, o_core_bias,
        output i_core_result,
        input  o_out_we, o_out_addr, o_out_data
    );
endinterface

// File: rtl/fc_layer_ctrl.sv
// Sequencer for one fully-connected MAC core: per output neuron it clears the core,
// streams NUM_IN node/weight pairs (bias only on the first beat), then writes the
// accumulated result to the output memory.
module fc_layer_ctrl #(
    parameter int IN_DATA_WIDTH = 9,
    parameter int NUM_IN        = 16,
    parameter int NUM_OUT       = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_start,
    input  logic                i_abort,
    output logic                o_idle,
    output logic                o_done,
    fc_layer_ctrl_if.master     bus
);
    localparam int NA_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int WA_W = (NUM_IN * NUM_OUT > 1) ? $clog2(NUM_IN * NUM_OUT) : 1;
    localparam int OA_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [NA_W-1:0]   in_cnt_reg, in_cnt_next;
    logic [OA_W-1:0]   out_cnt_reg, out_cnt_next;
    logic              valid_reg, valid_next;
    logic              first_reg, first_next;
    logic              abort_hit;
    logic              rd_en, core_run, out_we, done, idle;

    // State, counters and the one-cycle beat-delay flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            in_cnt_reg  <= '0;
            out_cnt_reg <= '0;
            valid_reg   <= 1'b0;
            first_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            in_cnt_reg  <= in_cnt_next;
            out_cnt_reg <= out_cnt_next;
            valid_reg   <= valid_next;
            first_reg   <= first_next;
        end
    end

    // Next-state, counter updates and state-decoded strobes.
    always_comb begin
        state_next   = state_reg;
        in_cnt_next  = in_cnt_reg;
        out_cnt_next = out_cnt_reg;
        rd_en        = 1'b0;
        core_run     = 1'b0;
        out_we       = 1'b0;
        done         = 1'b0;
        idle         = 1'b0;
        abort_hit    = (state_reg != S_IDLE) && i_abort;

        case (state_reg)
            S_IDLE: begin
                idle = 1'b1;
                if (i_start) begin
                    state_next   = S_CLEAR;
                    out_cnt_next = '0;
                end
            end
            S_CLEAR: begin
                core_run    = 1'b1;
                in_cnt_next = '0;
                state_next  = S_FEED;
            end
            S_FEED: begin
                rd_en = 1'b1;
                if (in_cnt_reg == NA_W'(NUM_IN - 1)) begin
                    state_next = S_DRAIN;
                end else begin
                    in_cnt_next = in_cnt_reg + NA_W'(1);
                end
            end
            S_DRAIN: begin
                state_next = S_WRITE;
            end
            S_WRITE: begin
                out_we = 1'b1;
                if (out_cnt_reg == OA_W'(NUM_OUT - 1)) begin
                    state_next = S_DONE;
                end else begin
                    out_cnt_next = out_cnt_reg + OA_W'(1);
                    state_next   = S_CLEAR;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Abort suppresses the write/done of this cycle; the read strobe of this
        // cycle still goes out, but its beat is never marked valid.
        if (abort_hit) begin
            state_next = S_IDLE;
            out_we     = 1'b0;
            done       = 1'b0;
        end

        valid_next = rd_en && !abort_hit;
        first_next = rd_en && (in_cnt_reg == '0) && !abort_hit;
    end

    // Strobes are masked while reset is held so nothing fires in the reset cycle.
    assign o_idle           = idle || !reset_n;
    assign o_done           = done && reset_n;
    assign bus.o_rd_en      = rd_en && reset_n;
    assign bus.o_core_run   = core_run && reset_n;
    assign bus.o_core_valid = valid_reg && reset_n;
    assign bus.o_out_we     = out_we && reset_n;

    assign bus.o_node_addr  = in_cnt_reg;
    assign bus.o_wegt_addr  = WA_W'(out_cnt_reg) * WA_W'(NUM_IN) + WA_W'(in_cnt_reg);
    assign bus.o_bias_addr  = out_cnt_reg;
    assign bus.o_out_addr   = out_cnt_reg;

    // Data path is pure steering; the core owns all arithmetic.
    assign bus.o_core_node  = bus.i_node_rdata;
    assign bus.o_core_wegt  = bus.i_wegt_rdata;
    assign bus.o_core_bias  = (first_reg && reset_n) ? bus.i_bias_rdata : '0;
    assign bus.o_out_data   = bus.o_out_we ? bus.i_core_result : '0;
endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Directed bench for fc_layer_ctrl: 4-input / 2-output layer with a behavioural
// memory and MAC core, covering results, timing, address trace, ignored restarts,
// abort and mid-layer reset.
module tb_fc_layer_ctrl;
    localparam int W    = 9;
    localparam int NI   = 4;
    localparam int NO   = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic i_start = 1'b0;
    logic i_abort = 1'b0;
    logic o_idle;
    logic o_done;

    int checks = 0;
    int errors = 0;

    fc_layer_ctrl_if #(.IN_DATA_WIDTH(W), .NUM_IN(NI), .NUM_OUT(NO)) bus ();

    fc_layer_ctrl #(.IN_DATA_WIDTH(W), .NUM_IN(NI), .NUM_OUT(NO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (i_start),
        .i_abort (i_abort),
        .o_idle  (o_idle),
        .o_done  (o_done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // behavioural memories with 1-cycle registered read
    logic [W-1:0] node_mem [NI];
    logic [W-1:0] wegt_mem [NI*NO];
    logic [W-1:0] bias_mem [NO];
    logic [W-1:0] node_q = '0;
    logic [W-1:0] wegt_q = '0;
    logic [W-1:0] bias_q = '0;

    always @(posedge clk) begin
        if (bus.o_rd_en) begin
            node_q <= node_mem[bus.o_node_addr];
            wegt_q <= wegt_mem[bus.o_wegt_addr];
            bias_q <= bias_mem[bus.o_bias_addr];
        end
    end

    assign bus.i_node_rdata = node_q;
    assign bus.i_wegt_rdata = wegt_q;
    assign bus.i_bias_rdata = bias_q;

    // behavioural signed MAC core: adds bias on every valid beat
    logic signed [4*W-1:0] acc = '0;
    logic signed [2*W-1:0] prod;
    assign prod = $signed(bus.o_core_node) * $signed(bus.o_core_wegt);

    always @(posedge clk) begin
        if (bus.o_core_run)
            acc <= '0;
        else if (bus.o_core_valid)
            acc <= acc + {{(2*W){prod[2*W-1]}}, prod}
                       + {{(3*W){bus.o_core_bias[W-1]}}, bus.o_core_bias};
    end

    assign bus.i_core_result = acc;

    // cycle bookkeeping and event logs
    int cyc = 0;
    int start_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           wr_addr_q [$];
    logic [35:0]  wr_data_q [$];
    int           wr_cyc_q  [$];
    int           done_q    [$];
    int           run_q     [$];
    int           na_q      [$];
    int           wa_q      [$];
    int           ba_q      [$];
    int           bias_nz;
    logic         idle5, rd5, valid5, idle14, we14, idle15;
    logic [7:0]   snap15;

    // Sample DUT outputs on the falling edge, tagged with cycle number relative to start.
    always @(negedge clk) begin
        int rel;
        rel = cyc - start_cyc;
        if (bus.o_out_we) begin
            wr_addr_q.push_back(int'(bus.o_out_addr));
            wr_data_q.push_back(bus.o_out_data);
            wr_cyc_q.push_back(rel);
        end
        if (o_done)          done_q.push_back(rel);
        if (bus.o_core_run)  run_q.push_back(rel);
        if (bus.o_rd_en) begin
            na_q.push_back(int'(bus.o_node_addr));
            wa_q.push_back(int'(bus.o_wegt_addr));
            ba_q.push_back(int'(bus.o_bias_addr));
        end
        if (bus.o_core_bias != '0) bias_nz = bias_nz + 1;
        if (rel == 5) begin
            idle5  = o_idle;
            rd5    = bus.o_rd_en;
            valid5 = bus.o_core_valid;
        end
        if (rel == 14) begin
            idle14 = o_idle;
            we14   = bus.o_out_we;
        end
        if (rel == 15) begin
            idle15 = o_idle;
            snap15 = {bus.o_rd_en, bus.o_core_run, bus.o_core_valid, bus.o_out_we,
                      o_done, (bus.o_core_bias != '0), (bus.o_out_data != '0), 1'b0};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        done_q.delete(); run_q.delete();
        na_q.delete(); wa_q.delete(); ba_q.delete();
        bias_nz = 0;
        idle5 = 1'bx; rd5 = 1'bx; valid5 = 1'bx;
        idle14 = 1'bx; we14 = 1'bx; idle15 = 1'bx; snap15 = 'x;
    endtask

    // Start a layer in relative cycle 0 and run a fixed window; optional
    // extra start pulses (cycles 3, 10), abort cycle and reset cycle.
    task automatic drive_layer(input bit pulse_again, input int abort_at,
                               input int reset_at, input int ncyc);
        @(posedge clk); #1;
        clear_logs();
        start_cyc = cyc;
        i_start = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            i_start = pulse_again && (k == 3 || k == 10);
            i_abort = (k == abort_at);
            reset_n = !(k == reset_at);
        end
        i_start = 1'b0;
        i_abort = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic load_case1();
        node_mem[0] = 9'd1; node_mem[1] = 9'd2; node_mem[2] = 9'd3; node_mem[3] = 9'd4;
        for (int i = 0; i < 4; i++) wegt_mem[i] = 9'd1;
        wegt_mem[4] = 9'h1FF; wegt_mem[5] = 9'd2; wegt_mem[6] = 9'd0; wegt_mem[7] = 9'd3;
        bias_mem[0] = 9'd5; bias_mem[1] = 9'h1FE;
    endtask

    task automatic check_case1_results(input string tag);
        chk({tag, "_wr_count"}, 64'(wr_data_q.size()), 64'd2);
        if (wr_data_q.size() == 2) begin
            chk({tag, "_out0_addr"}, 64'(wr_addr_q[0]), 64'd0);
            chk({tag, "_out0_data"}, 64'(wr_data_q[0]), 64'd15);
            chk({tag, "_out0_cyc"},  64'(wr_cyc_q[0]),  64'd7);
            chk({tag, "_out1_addr"}, 64'(wr_addr_q[1]), 64'd1);
            chk({tag, "_out1_data"}, 64'(wr_data_q[1]), 64'd13);
            chk({tag, "_out1_cyc"},  64'(wr_cyc_q[1]),  64'd14);
        end
        chk({tag, "_done_count"}, 64'(done_q.size()), 64'd1);
        if (done_q.size() == 1) chk({tag, "_done_cyc"}, 64'(done_q[0]), 64'd15);
    endtask

    initial begin
        clear_logs();
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_idle",  64'(o_idle), 64'd1);
        chk("rst_rd_en", 64'(bus.o_rd_en), 64'd0);
        chk("rst_we",    64'(bus.o_out_we), 64'd0);
        chk("rst_done",  64'(o_done), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle",  64'(o_idle), 64'd1);
        chk("post_rst_valid", 64'(bus.o_core_valid), 64'd0);

        // case 1 + case 3: results, timing and address trace
        load_case1();
        drive_layer(1'b0, -1, -1, 20);
        check_case1_results("c1");
        chk("c3_rd_count", 64'(wa_q.size()), 64'd8);
        if (wa_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("c3_wegt_addr%0d", i), 64'(wa_q[i]), 64'(i));
                chk($sformatf("c3_node_addr%0d", i), 64'(na_q[i]), 64'(i % 4));
                chk($sformatf("c3_bias_addr%0d", i), 64'(ba_q[i]), 64'(i / 4));
            end
        end
        chk("c3_run_count", 64'(run_q.size()), 64'd2);
        if (run_q.size() == 2) begin
            chk("c3_run0_cyc", 64'(run_q[0]), 64'd1);
            chk("c3_run1_cyc", 64'(run_q[1]), 64'd8);
        end
        chk("c1_bias_beats", 64'(bias_nz), 64'd2);
        chk("c1_idle_after", 64'(o_idle), 64'd1);

        // case 2: bias only on the first beat of each neuron
        for (int i = 0; i < 4; i++) node_mem[i] = 9'd0;
        for (int i = 0; i < 8; i++) wegt_mem[i] = 9'd0;
        bias_mem[0] = 9'd7; bias_mem[1] = 9'd7;
        drive_layer(1'b0, -1, -1, 20);
        chk("c2_wr_count", 64'(wr_data_q.size()), 64'd2);
        if (wr_data_q.size() == 2) begin
            chk("c2_out0_data", 64'(wr_data_q[0]), 64'd7);
            chk("c2_out1_data", 64'(wr_data_q[1]), 64'd7);
        end
        chk("c2_bias_beats", 64'(bias_nz), 64'd2);

        // case 4: extra start pulses while busy are ignored
        load_case1();
        drive_layer(1'b1, -1, -1, 20);
        check_case1_results("c4");
        chk("c4_run_count", 64'(run_q.size()), 64'd2);

        // case 5: abort during FEED of neuron 0, then restart
        drive_layer(1'b0, 4, -1, 20);
        chk("c5_idle5",    64'(idle5), 64'd1);
        chk("c5_rd5",      64'(rd5), 64'd0);
        chk("c5_valid5",   64'(valid5), 64'd0);
        chk("c5_wr_count", 64'(wr_data_q.size()), 64'd0);
        chk("c5_done_cnt", 64'(done_q.size()), 64'd0);
        chk("c5_rd_count", 64'(wa_q.size()), 64'd3);
        drive_layer(1'b0, -1, -1, 20);
        check_case1_results("c5r");

        // case 6: reset pulse during WRITE of neuron 1
        drive_layer(1'b0, -1, 14, 20);
        chk("c6_we14",      64'(we14), 64'd0);
        chk("c6_idle14",    64'(idle14), 64'd1);
        chk("c6_idle15",    64'(idle15), 64'd1);
        chk("c6_outs15",    64'(snap15), 64'd0);
        chk("c6_wr_count",  64'(wr_data_q.size()), 64'd1);
        chk("c6_done_cnt",  64'(done_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
